adc_spi_capture: RTL
====================

// Module: adc_spi_capture
// PURPOSE
//  Parametrised serial-ADC front end: generates cs_1/sclk_1, shifts in one frame per sample period,
//  checks leading-zero bits, optionally averages 2^AVG_LOG2 frames, presents a registered sample + strobe.
//  Successor to the fixed 16-bit ADC receiver; feeds the PID/truncation datapath of the servo loop.
// PARAMETERS
//  FRAME_BITS    16    sclk cycles (bits) per conversion frame, MSB first
//  DATA_BITS     12    payload bits = last DATA_BITS of the frame
//  LEAD_ZEROS    4     leading frame bits that must read 0 (FRAME_BITS = LEAD_ZEROS + DATA_BITS)
//  CLK_DIV       10    Clk cycles per sclk half-period (>=1)
//  CS_SETUP      4     Clk cycles from cs_1 fall to first sclk fall
//  CS_HOLD       4     Clk cycles from last sclk rise to cs_1 rise
//  SAMPLE_PERIOD 1000  Clk cycles between conversion starts
//  AVG_LOG2      0     averaging depth exponent (0 = no averaging, max 4)
// PORTS
//  Clk           in   1          system clock, all logic on rising edge
//  Rest          in   1          synchronous, active-high reset
//  enable        in   1          1 = run conversions at SAMPLE_PERIOD rate
//  DataIn        in   1          ADC serial data
//  cs_1          out  1          ADC chip select, active low
//  sclk_1        out  1          ADC serial clock, idles high
//  sample        out  DATA_BITS  latest (averaged) payload, unsigned
//  sample_valid  out  1          one-Clk pulse when sample updates
//  frame_err     out  1          one-Clk pulse: a leading bit was 1, frame discarded
//  busy          out  1          1 while cs_1 low
// BEHAVIOUR
//  Reset: cs_1=1, sclk_1=1, sample=0, sample_valid=0, frame_err=0, busy=0; FSM=IDLE;
//   period counter, bit counter, accumulator, average count cleared. Reset mid-frame aborts it; cs_1 high next edge.
//  Period counter: runs 0..SAMPLE_PERIOD-1 while enable=1; held at 0 while enable=0. A start is issued at count 0.
//  FSM: IDLE -(start)-> SETUP (cs_1=0, CS_SETUP cycles) -> SHIFT -> HOLD (CS_HOLD cycles) -> UPDATE (1 cycle) -> IDLE.
//  SHIFT: per bit, sclk_1 low CLK_DIV cycles then high CLK_DIV cycles; DataIn registered into the shift reg
//   on the Clk edge that drives sclk_1 1->0 (data stable from previous rise); exactly FRAME_BITS falls and rises.
//  UPDATE: cs_1 already high. If any of the LEAD_ZEROS MSBs =1: frame_err=1, frame not accumulated.
//   Else payload added to accumulator (DATA_BITS+AVG_LOG2 wide, no overflow possible); avg count++;
//   when avg count wraps to 0: sample <= acc >> AVG_LOG2 (truncating), sample_valid=1, acc cleared.
//  Latency: sample_valid asserts CS_HOLD+1 cycles after final sclk rise, 1 cycle after cs_1 rises;
//   sample stable until next update.
//  enable falling mid-frame: frame completes and is processed normally; no new start. enable rising: start at
//   next count 0 (immediately, counter held at 0). Averaging accumulation persists across enable gaps.
//  Elaboration check ($error): SAMPLE_PERIOD >= CS_SETUP + 2*CLK_DIV*FRAME_BITS + CS_HOLD + 2;
//   FRAME_BITS == LEAD_ZEROS+DATA_BITS. With this, starts never overlap a frame (no overrun path).
// STRUCTURE
//  Package adc_spi_pkg: FSM state enum (IDLE, SETUP, SHIFT, HOLD, UPDATE), clog2 function, frame-length constant.
//  Sub-module adc_sclk_div: CLK_DIV counter emitting fall/rise enable pulses and sclk level; gated by FSM=SHIFT.
//  Top holds FSM, period counter, bit counter, shift reg, accumulator, output regs.
// TESTING (FRAME_BITS=16, DATA_BITS=12, LEAD_ZEROS=4, CLK_DIV=2, CS_SETUP=CS_HOLD=2, SAMPLE_PERIOD=100)
//  1 ADC model returns 16'h0ABC -> sample=12'hABC, one sample_valid pulse, frame_err=0, 16 sclk falls per cs_1 low.
//  2 frames 16'h0FFF, 16'h0000 -> samples 12'hFFF then 12'h000; cs_1 falls exactly 100 Clk apart.
//  3 frame 16'h8123 -> frame_err pulse, no sample_valid, sample keeps previous value.
//  4 AVG_LOG2=2, frames 16'h0001,0002,0003,0006 -> single sample_valid after 4th frame, sample=12'h003.
//  5 Rest=1 during bit 7 of a frame -> next edge cs_1=1, sclk_1=1, sample=0; after release, clean frame decodes.
//  6 enable drops during SHIFT -> frame completes with sample_valid; no further cs_1 fall while enable=0.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared state encoding and elaboration helpers for the serial-ADC capture front end.
package adc_spi_pkg;

  localparam int FRAME_LEN = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    UPDATE
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/adc_sclk_div.sv
// Serial clock generator: divides Clk into sclk half-periods and flags the edges that move sclk.
module adc_sclk_div
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_run,
  output logic o_fall,
  output logic o_rise,
  output logic o_sclk
);

  localparam int DIV_W = clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_halfDone;

  // The first fall comes from i_start so it lands on the same edge the FSM enters SHIFT.
  assign w_halfDone = (r_cnt == DIV_LAST);
  assign o_fall     = i_start || (i_run && r_sclk && w_halfDone);
  assign o_rise     = i_run && !r_sclk && w_halfDone;
  assign o_sclk     = r_sclk;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (o_fall) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (o_rise) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (i_run) begin
      r_cnt  <= r_cnt + DIV_W'(1);
    end else begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// Serial-ADC front end: frames a conversion every sample period, checks leading zeros,
// optionally averages 2^AVG_LOG2 frames and presents a registered sample with a strobe.
module adc_spi_capture
  import adc_spi_pkg::*;
#(
  parameter int FRAME_BITS    = FRAME_LEN,
  parameter int DATA_BITS     = 12,
  parameter int LEAD_ZEROS    = 4,
  parameter int CLK_DIV       = 10,
  parameter int CS_SETUP      = 4,
  parameter int CS_HOLD       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 0
) (
  input  logic                 Clk,
  input  logic                 Rest,
  input  logic                 enable,
  input  logic                 DataIn,
  output logic                 cs_1,
  output logic                 sclk_1,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int PER_W  = clog2(SAMPLE_PERIOD + 1);
  localparam int BIT_W  = clog2(FRAME_BITS + 1);
  localparam int WAIT_W = clog2(((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD) + 1);
  localparam int ACC_W  = DATA_BITS + AVG_LOG2;
  localparam int AVGC_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;

  localparam logic [PER_W-1:0]  PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD - 1);
  localparam logic [AVGC_W-1:0] AVG_LAST   = AVGC_W'((1 << AVG_LOG2) - 1);

  // A period long enough for a whole frame is what guarantees starts never overlap a frame.
  if (SAMPLE_PERIOD < CS_SETUP + 2 * CLK_DIV * FRAME_BITS + CS_HOLD + 2) begin : g_badPeriod
    $error("adc_spi_capture: SAMPLE_PERIOD too short for one frame");
  end
  if (FRAME_BITS != LEAD_ZEROS + DATA_BITS) begin : g_badFrame
    $error("adc_spi_capture: FRAME_BITS must equal LEAD_ZEROS + DATA_BITS");
  end
  if (CLK_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1 || AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_badTiming
    $error("adc_spi_capture: CLK_DIV, CS_SETUP, CS_HOLD must be >= 1 and AVG_LOG2 in 0..4");
  end

  state_t               r_state;
  state_t               w_nextState;
  logic [PER_W-1:0]     r_periodCnt;
  logic [BIT_W-1:0]     r_bitCnt;
  logic [WAIT_W-1:0]    r_waitCnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [ACC_W-1:0]     r_acc;
  logic [AVGC_W-1:0]    r_avgCnt;
  logic [DATA_BITS-1:0] r_sample;
  logic                 r_valid;
  logic                 r_err;

  logic                 w_start;
  logic                 w_sclkStart;
  logic                 w_fall;
  logic                 w_rise;
  logic                 w_leadBad;
  logic                 w_avgWrap;
  logic [ACC_W-1:0]     w_accSum;
  logic [DATA_BITS-1:0] w_avgOut;

  adc_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sclkDiv (
    .i_clock(Clk),
    .i_reset(Rest),
    .i_start(w_sclkStart),
    .i_run  (r_state == SHIFT),
    .o_fall (w_fall),
    .o_rise (w_rise),
    .o_sclk (sclk_1)
  );

  if (LEAD_ZEROS > 0) begin : g_lead
    assign w_leadBad = |r_shift[FRAME_BITS-1 -: LEAD_ZEROS];
  end else begin : g_noLead
    assign w_leadBad = 1'b0;
  end

  assign w_start   = enable && (r_periodCnt == '0) && (r_state == IDLE);
  assign w_accSum  = r_acc + ACC_W'(r_shift[DATA_BITS-1:0]);
  assign w_avgOut  = DATA_BITS'(w_accSum >> AVG_LOG2);
  assign w_avgWrap = (AVG_LOG2 == 0) || (r_avgCnt == AVG_LAST);

  assign busy         = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
  assign cs_1         = !busy;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign frame_err    = r_err;

  always_comb begin
    w_nextState = r_state;
    w_sclkStart = 1'b0;
    case (r_state)
      IDLE:    if (w_start) w_nextState = SETUP;
      SETUP: begin
        if (r_waitCnt == SETUP_LAST) begin
          w_nextState = SHIFT;
          w_sclkStart = 1'b1;
        end
      end
      SHIFT:   if (w_rise && (r_bitCnt == BIT_LAST)) w_nextState = HOLD;
      HOLD:    if (r_waitCnt == HOLD_LAST) w_nextState = UPDATE;
      UPDATE:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Frame sequencing; the wait counter restarts on every state change and times SETUP/HOLD.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      r_state     <= IDLE;
      r_periodCnt <= '0;
      r_bitCnt    <= '0;
      r_waitCnt   <= '0;
      r_shift     <= '0;
    end else begin
      r_state <= w_nextState;
      if (!enable || (r_periodCnt == PER_LAST)) r_periodCnt <= '0;
      else r_periodCnt <= r_periodCnt + PER_W'(1);
      if (w_nextState != r_state) r_waitCnt <= '0;
      else r_waitCnt <= r_waitCnt + WAIT_W'(1);
      if (r_state == IDLE) r_bitCnt <= '0;
      else if (w_rise) r_bitCnt <= r_bitCnt + BIT_W'(1);
      if (w_fall) r_shift <= {r_shift[FRAME_BITS-2:0], DataIn};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      r_acc    <= '0;
      r_avgCnt <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == UPDATE) begin
        if (w_leadBad) begin
          r_err <= 1'b1;
        end else begin
          r_avgCnt <= r_avgCnt + AVGC_W'(1);
          if (w_avgWrap) begin
            r_sample <= w_avgOut;
            r_valid  <= 1'b1;
            r_acc    <= '0;
          end else begin
            r_acc <= w_accSum;
          end
        end
      end
    end
  end

endmodule
